// File: rtl/microwire_serial_seq.sv
// microwire_serial_seq: Microwire (93Cxx-style) serial EEPROM sequencer.
// Runs READ, WRITE, ERASE and EWEN/EWDS frames. After WRITE and ERASE it
// polls the device for ready.
// Optional feature macro MW_TIMEOUT_EN: bounds the ready poll to TMO_CYC SK
// periods and raises err when that bound expires. Without it, err is tied 0.
module microwire_serial_seq #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4,
  parameter int TMO_CYC = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              ee_cs,
  output logic              ee_sk,
  output logic              ee_di,
  input  logic              ee_do
);

  localparam int CMD_BITS = 3 + ADDR_W;
  localparam int BCW      = $clog2(CMD_BITS + DATA_W);
  localparam int DVW      = $clog2(2*CLK_DIV + 1);

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ERASE = 2'b11;

  if (CLK_DIV < 1 || TMO_CYC < 1) begin : g_bad_param
    $error("microwire_serial_seq: CLK_DIV and TMO_CYC must be >= 1");
  end

  typedef enum logic [2:0] {IDLE, CSUP, CMD, RDAT, WDAT, CSGAP, POLL, FIN} state_t;

  state_t              state;
  logic [DVW-1:0]      div;
  logic [BCW-1:0]      bit_cnt;
  logic [1:0]          op_q;
  logic [CMD_BITS-1:0] cmd_sr;
  logic [DATA_W-1:0]   wd_sr;
  logic [DATA_W-2:0]   rd_sr;   // last bit goes straight into rdata
  logic                rdy;

  logic half_tick, gap_tick, shifting, sk_rise, sk_fall, last_cmd, last_dat;

`ifdef MW_TIMEOUT_EN
  localparam int TCW = $clog2(TMO_CYC + 1);
  logic [TCW-1:0] tmo_cnt;
  logic           err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // SK half-period and CS-gap strobes; SK edges exist only in shifting states
  assign half_tick = (div == DVW'(CLK_DIV - 1));
  assign gap_tick  = (div == DVW'(2*CLK_DIV - 1));
  assign shifting  = (state == CMD) || (state == RDAT) || (state == WDAT) || (state == POLL);
  assign sk_rise   = shifting && half_tick && !ee_sk;
  assign sk_fall   = shifting && half_tick &&  ee_sk;
  assign last_cmd  = (bit_cnt == BCW'(CMD_BITS - 1));
  assign last_dat  = (bit_cnt == BCW'(DATA_W - 1));

  // Sequencer: one state register, all pins and status registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      div     <= '0;
      bit_cnt <= '0;
      op_q    <= '0;
      cmd_sr  <= '0;
      wd_sr   <= '0;
      rd_sr   <= '0;
      rdy     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
      ee_cs   <= 1'b0;
      ee_sk   <= 1'b0;
      ee_di   <= 1'b0;
`ifdef MW_TIMEOUT_EN
      tmo_cnt <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      div  <= half_tick ? '0 : div + 1'b1;
      if (shifting && half_tick) ee_sk <= ~ee_sk;
      case (state)
        IDLE: begin
          div <= '0;
          // a req coinciding with the done pulse is deliberately dropped
          if (req && !busy && !done) begin
            busy   <= 1'b1;
            op_q   <= op;
            cmd_sr <= {1'b1, op, addr};
            wd_sr  <= wdata;
            state  <= CSUP;
`ifdef MW_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
          end
        end
        CSUP: begin
          // first cycle raises CS, then CS setup for CLK_DIV clk with SK low
          if (!ee_cs) begin
            ee_cs <= 1'b1;
            div   <= '0;
          end else if (half_tick) begin
            ee_di   <= cmd_sr[CMD_BITS-1];
            cmd_sr  <= cmd_sr << 1;
            bit_cnt <= '0;
            state   <= CMD;
          end
        end
        CMD: begin
          if (sk_fall) begin
            if (last_cmd) begin
              bit_cnt <= '0;
              case (op_q)
                OP_READ:  begin ee_di <= 1'b0; state <= RDAT; end
                OP_WRITE: begin
                  ee_di <= wd_sr[DATA_W-1];
                  wd_sr <= wd_sr << 1;
                  state <= WDAT;
                end
                OP_ERASE: begin ee_di <= 1'b0; ee_cs <= 1'b0; state <= CSGAP; end
                default:  begin ee_di <= 1'b0; ee_cs <= 1'b0; state <= FIN; end
              endcase
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              ee_di   <= cmd_sr[CMD_BITS-1];
              cmd_sr  <= cmd_sr << 1;
            end
          end
        end
        RDAT: begin
          if (sk_rise) begin
            rd_sr <= {rd_sr[DATA_W-3:0], ee_do};
            if (last_dat) rdata <= {rd_sr, ee_do};
          end
          if (sk_fall) begin
            if (last_dat) begin
              bit_cnt <= '0;
              ee_cs   <= 1'b0;
              state   <= FIN;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        WDAT: begin
          if (sk_fall) begin
            if (last_dat) begin
              bit_cnt <= '0;
              ee_di   <= 1'b0;
              ee_cs   <= 1'b0;
              state   <= CSGAP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              ee_di   <= wd_sr[DATA_W-1];
              wd_sr   <= wd_sr << 1;
            end
          end
        end
        CSGAP: begin
          // CS low for one full SK period starts the device's busy/ready phase
          div <= gap_tick ? '0 : div + 1'b1;
          if (gap_tick) begin
            ee_cs <= 1'b1;
            rdy   <= 1'b0;
            state <= POLL;
`ifdef MW_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end
        POLL: begin
          if (sk_rise) rdy <= ee_do;
          // leave only on a falling edge so the last SK period is complete
          if (sk_fall) begin
            if (rdy) begin
              ee_cs <= 1'b0;
              state <= FIN;
            end
`ifdef MW_TIMEOUT_EN
            else if (tmo_cnt == TCW'(TMO_CYC - 1)) begin
              ee_cs <= 1'b0;
              err_q <= 1'b1;
              state <= FIN;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
`endif
          end
        end
        FIN: begin
          if (half_tick) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_microwire_serial_seq.sv
// tb_microwire_serial_seq: scoreboard bench with a clk-synchronous 93Cxx model.
module tb_microwire_serial_seq;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int CD = 2;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n, req;
  logic [1:0]    op;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          busy, done, err, ee_cs, ee_sk, ee_di;
  logic [DW-1:0] rdata;
  logic          ee_do = 1'b0;

  microwire_serial_seq #(.ADDR_W(AW), .DATA_W(DW), .CLK_DIV(CD), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .err(err),
    .ee_cs(ee_cs), .ee_sk(ee_sk), .ee_di(ee_di), .ee_do(ee_do)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          ndi;
    logic [31:0] frame;
    int          lat;
    int          polls;
    int          gap;
  } exp_t;

  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // config written only by the stimulus process
  logic [15:0] mdl_data = '0;
  int          poll_zero = 0;

  // model / monitor state written only by the monitor process
  int          cyc = 0, t_acc = 0, n_acc = 0;
  int          frame = 0, rc = 0, di_n = 0, polls = 0, gap = 0, glitch = 0;
  logic [31:0] di_vec = '0;
  logic        is_rd = 1'b0;
  logic        busy_p = 1'b0, cs_p = 1'b0, sk_p = 1'b0, di_p = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic push_exp(input logic [15:0] rd, input logic er, input int ndi,
                          input logic [31:0] fr, input int lat, input int pl, input int gp);
    exp_t e;
    e.rdata = rd; e.err = er; e.ndi = ndi; e.frame = fr;
    e.lat = lat; e.polls = pl; e.gap = gp;
    sb_q.push_back(e);
  endtask

  always @(posedge clk) cyc++;

  // EEPROM model + monitor + scoreboard, all away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (busy && !busy_p) begin
      frame = 0; rc = 0; di_n = 0; di_vec = '0; polls = 0; gap = 0; glitch = 0;
      is_rd = 1'b0; ee_do = 1'b0; t_acc = cyc; n_acc++;
    end
    if (ee_cs && !cs_p) begin
      rc = 0;
      frame++;
      ee_do = (frame == 2) ? (poll_zero == 0) : 1'b0;
    end
    if (ee_sk && !sk_p && ee_cs) begin
      rc++;
      if (frame == 1) begin
        di_vec = {di_vec[30:0], ee_di};
        di_n++;
        if (di_n == 3) is_rd = (di_vec[2:0] == 3'b110);
      end else if (frame == 2) begin
        polls++;
      end
    end
    if (!ee_sk && sk_p && ee_cs) begin
      if (frame == 1 && is_rd && rc >= 3 + AW && rc < 3 + AW + DW)
        ee_do = mdl_data[DW-1-(rc-(3+AW))];
      else if (frame == 2)
        ee_do = (polls >= poll_zero);
      else
        ee_do = 1'b0;
    end
    if (!ee_cs && frame == 1 && busy) gap++;
    if (ee_sk && sk_p && ee_di !== di_p) glitch++;
    if (done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("rdata", 32'(rdata), 32'(e.rdata));
        chk("err", 32'(err), 32'(e.err));
        chk("di_bits", 32'(di_n), 32'(e.ndi));
        chk("di_frame", di_vec, e.frame);
        chk("di_stable", 32'(glitch), 32'd0);
        if (e.lat >= 0)   chk("latency", 32'(cyc - t_acc), 32'(e.lat));
        if (e.polls >= 0) chk("poll_rises", 32'(polls), 32'(e.polls));
        if (e.gap >= 0)   chk("cs_gap", 32'(gap), 32'(e.gap));
      end
    end
    busy_p = busy; cs_p = ee_cs; sk_p = ee_sk; di_p = ee_di;
  end

  task automatic issue(input logic [1:0] o, input logic [AW-1:0] a,
                       input logic [DW-1:0] w, input int hold);
    int n = 0;
    while ((busy || done) && n < 3000) begin @(negedge clk); n++; end
    chk("issue_idle", 32'(busy), 32'd0);
    op = o; addr = a; wdata = w; req = 1'b1;
    repeat (hold) @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 3000) begin @(negedge clk); n++; end
    chk("done_seen", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    int a0;
    rst_n = 1'b0; req = 1'b0; op = '0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cs", 32'(ee_cs), 32'd0);
    chk("rst_sk", 32'(ee_sk), 32'd0);
    chk("rst_di", 32'(ee_di), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // reset in the middle of a READ command phase
    mdl_data = 16'hFFFF;
    issue(2'b10, 6'h2B, '0, 1);
    repeat (8) @(negedge clk);
    chk("pre_rst_cs", 32'(ee_cs), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_cs", 32'(ee_cs), 32'd0);
    chk("midrst_sk", 32'(ee_sk), 32'd0);
    chk("midrst_di", 32'(ee_di), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin @(negedge clk); if (done) cnt++; end
    chk("midrst_no_done", 32'(cnt), 32'd0);

    // READ 0x15 -> 0xA5C3
    mdl_data = 16'hA5C3;
    push_exp(16'hA5C3, 1'b0, 25, {7'd0, 3'b110, 6'h15, 16'h0}, 105, 0, -1);
    issue(2'b10, 6'h15, '0, 1);
    wait_done();

    // WRITE 0x3F <- 0x1234, device busy for 5 poll periods
    poll_zero = 5;
    push_exp(16'hA5C3, 1'b0, 25, {7'd0, 3'b101, 6'h3F, 16'h1234}, 133, 6, 2*CD);
    issue(2'b01, 6'h3F, 16'h1234, 1);
    wait_done();

    // EWEN: no poll phase
    push_exp(16'hA5C3, 1'b0, 9, {23'd0, 3'b100, 6'h30}, 41, 0, -1);
    issue(2'b00, 6'h30, '0, 1);
    wait_done();

    // back-to-back: req held 3 cycles, then a req in the done cycle
    mdl_data = 16'h5A3C;
    a0 = n_acc;
    push_exp(16'h5A3C, 1'b0, 25, {7'd0, 3'b110, 6'h2A, 16'h0}, 105, 0, -1);
    issue(2'b10, 6'h2A, '0, 3);
    cnt = 0;
    while (!done && cnt < 3000) begin @(negedge clk); cnt++; end
    chk("b2b_done", 32'(done), 32'd1);
    op = 2'b10; addr = 6'h11; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    cnt = 0;
    repeat (6) begin if (busy) cnt++; @(negedge clk); end
    chk("b2b_busy_after", 32'(cnt), 32'd0);
    chk("b2b_accepts", 32'(n_acc - a0), 32'd1);

    // ERASE with a short busy phase
    poll_zero = 2;
    push_exp(16'h5A3C, 1'b0, 9, {23'd0, 3'b111, 6'h05}, 57, 3, 2*CD);
    issue(2'b11, 6'h05, '0, 1);
    wait_done();

`ifdef MW_TIMEOUT_EN
    // ERASE with ee_do stuck low: bounded poll then err
    poll_zero = 100000;
    push_exp(16'h5A3C, 1'b1, 9, {23'd0, 3'b111, 6'h07}, 77, TMO, 2*CD);
    issue(2'b11, 6'h07, '0, 1);
    wait_done();
    chk("tmo_err_held", 32'(err), 32'd1);
    // next READ clears err
    mdl_data = 16'h0F0F;
    push_exp(16'h0F0F, 1'b0, 25, {7'd0, 3'b110, 6'h01, 16'h0}, 105, 0, -1);
    issue(2'b10, 6'h01, '0, 1);
    wait_done();
`endif

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
